// File: rtl/line_clear_ctl_pkg.sv
// Shared playfield definitions: board geometry, scoring constants, the
// line-clear sequencer state encoding and the board RAM write payload.
package line_clear_ctl_pkg;

  localparam int unsigned ROWS            = 20;
  localparam int unsigned COLS            = 10;
  localparam int unsigned SPAWN_ROWS      = 2;
  localparam int unsigned LINES_PER_LEVEL = 10;
  localparam int unsigned MAX_LEVEL       = 15;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TOTAL_W = 10;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned PROG_W  = 4;

  localparam logic [COLS-1:0]   FULL_ROW = {COLS{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SCAN_ADDR,
    ST_SCAN_WAIT,
    ST_SCAN_EVAL,
    ST_FILL,
    ST_DONE
  } lc_state_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [COLS-1:0]   data;
  } ram_wr_t;

endpackage

// File: rtl/line_clear_ctl_stats.sv
// Line statistics: saturating line total, progress-to-next-level counter
// and saturating level.
//   pclk, rst     : clock, synchronous active-high reset
//   clr           : zero all statistics (new game)
//   commit        : add count to the statistics this cycle
//   count         : rows removed by the finished scan
//   lines_total   : accumulated cleared lines (saturates at all-ones)
//   level         : current level (saturates at MAX_LEVEL)
module line_clear_ctl_stats
  import line_clear_ctl_pkg::*;
(
  input  logic               pclk,
  input  logic               rst,
  input  logic               clr,
  input  logic               commit,
  input  logic [CNT_W-1:0]   count,
  output logic [TOTAL_W-1:0] lines_total,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned TSUM_W = TOTAL_W + 1;
  localparam int unsigned PSUM_W = PROG_W + 1;

  logic [TOTAL_W-1:0] total_q, total_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PROG_W-1:0]  prog_q,  prog_d;
  logic [TSUM_W-1:0]  total_sum;
  logic [PSUM_W-1:0]  prog_sum;

  // Next-state statistics; a single commit crosses at most one level boundary.
  always_comb begin
    total_d   = total_q;
    level_d   = level_q;
    prog_d    = prog_q;
    total_sum = {1'b0, total_q} + TSUM_W'(count);
    prog_sum  = {1'b0, prog_q} + PSUM_W'(count);
    if (clr) begin
      total_d = '0;
      level_d = '0;
      prog_d  = '0;
    end else if (commit) begin
      total_d = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
      if (prog_sum >= PSUM_W'(LINES_PER_LEVEL)) begin
        prog_d = PROG_W'(prog_sum - PSUM_W'(LINES_PER_LEVEL));
        if (level_q != LEVEL_W'(MAX_LEVEL)) begin
          level_d = level_q + LEVEL_W'(1);
        end
      end else begin
        prog_d = prog_sum[PROG_W-1:0];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      total_q <= '0;
      level_q <= '0;
      prog_q  <= '0;
    end else begin
      total_q <= total_d;
      level_q <= level_d;
      prog_q  <= prog_d;
    end
  end

  assign lines_total = total_q;
  assign level       = level_q;

endmodule

// File: rtl/line_clear_ctl.sv
// Line-clear sequencer for the playfield board RAM. After a piece locks it
// scans rows bottom-up, drops full rows, compacts the rest downward and
// zero-fills the freed top rows; new_game wipes the whole board.
//   pclk, rst       : clock, synchronous active-high reset
//   new_game, lock  : command pulses (new_game wins, accepted any time)
//   rd_addr/rd_data : board RAM read port (1-cycle read latency)
//   wr_en/addr/data : board RAM write port
//   busy, done      : sequencer status / end-of-operation pulse
//   lines_cleared   : rows removed by the last scan
//   lines_total, level, game_over : game statistics
module line_clear_ctl
  import line_clear_ctl_pkg::*;
(
  input  logic               pclk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               lock,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COLS-1:0]    rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLS-1:0]    wr_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   lines_cleared,
  output logic [TOTAL_W-1:0] lines_total,
  output logic [LEVEL_W-1:0] level,
  output logic               game_over
);

  lc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_row_q, rd_row_d;
  logic [ADDR_W-1:0] wr_row_q, wr_row_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              go_flag_q, go_flag_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  ram_wr_t           wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  lines_cleared_q, lines_cleared_d;
  logic              game_over_q, game_over_d;
  logic              stats_clr_c;
  logic              stats_commit_c;

  // Next-state and output decode.
  always_comb begin
    state_d         = state_q;
    rd_row_d        = rd_row_q;
    wr_row_d        = wr_row_q;
    count_d         = count_q;
    go_flag_d       = go_flag_q;
    rd_addr_d       = rd_addr_q;
    wr_d            = '0;
    done_d          = 1'b0;
    lines_cleared_d = lines_cleared_q;
    game_over_d     = game_over_q;
    stats_clr_c     = 1'b0;
    stats_commit_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lock) begin
          rd_row_d  = LAST_ROW;
          wr_row_d  = LAST_ROW;
          count_d   = '0;
          go_flag_d = 1'b0;
          state_d   = ST_SCAN_ADDR;
        end
      end

      // wr_row doubles as the clear pointer, counting up from row 0.
      ST_CLR: begin
        wr_d.en   = 1'b1;
        wr_d.addr = wr_row_q;
        wr_d.data = '0;
        if (wr_row_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          wr_row_d = wr_row_q + ADDR_W'(1);
        end
      end

      ST_SCAN_ADDR: begin
        rd_addr_d = rd_row_q;
        state_d   = ST_SCAN_WAIT;
      end

      ST_SCAN_WAIT: begin
        state_d = ST_SCAN_EVAL;
      end

      // Keep non-full rows by moving them to wr_row; wr_row never passes
      // above rd_row, so a write never clobbers a row still to be read.
      ST_SCAN_EVAL: begin
        if (rd_data == FULL_ROW) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          if (wr_row_q != rd_row_q) begin
            wr_d.en   = 1'b1;
            wr_d.addr = wr_row_q;
            wr_d.data = rd_data;
          end
          if ((rd_data != '0) && (wr_row_q < ADDR_W'(SPAWN_ROWS))) begin
            go_flag_d = 1'b1;
          end
          wr_row_d = wr_row_q - ADDR_W'(1);
        end
        if (rd_row_q == '0) begin
          state_d = (count_d == '0) ? ST_DONE : ST_FILL;
        end else begin
          rd_row_d = rd_row_q - ADDR_W'(1);
          state_d  = ST_SCAN_ADDR;
        end
      end

      // After the scan wr_row == count-1: the topmost freed row index.
      ST_FILL: begin
        wr_d.en   = 1'b1;
        wr_d.addr = wr_row_q;
        wr_d.data = '0;
        if (wr_row_q == '0) begin
          state_d = ST_DONE;
        end else begin
          wr_row_d = wr_row_q - ADDR_W'(1);
        end
      end

      ST_DONE: begin
        done_d          = 1'b1;
        lines_cleared_d = count_q;
        stats_commit_c  = 1'b1;
        game_over_d     = game_over_q | go_flag_q;
        state_d         = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // new_game aborts anything in flight; CLR rewrites every row anyway.
    if (new_game) begin
      state_d        = ST_CLR;
      wr_row_d       = '0;
      count_d        = '0;
      go_flag_d      = 1'b0;
      game_over_d    = 1'b0;
      wr_d           = '0;
      done_d         = 1'b0;
      stats_clr_c    = 1'b1;
      stats_commit_c = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rd_row_q        <= '0;
      wr_row_q        <= '0;
      count_q         <= '0;
      go_flag_q       <= 1'b0;
      rd_addr_q       <= '0;
      wr_q            <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      lines_cleared_q <= '0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_row_q        <= rd_row_d;
      wr_row_q        <= wr_row_d;
      count_q         <= count_d;
      go_flag_q       <= go_flag_d;
      rd_addr_q       <= rd_addr_d;
      wr_q            <= wr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      lines_cleared_q <= lines_cleared_d;
      game_over_q     <= game_over_d;
    end
  end

  line_clear_ctl_stats u_stats (
    .pclk        (pclk),
    .rst         (rst),
    .clr         (stats_clr_c),
    .commit      (stats_commit_c),
    .count       (count_q),
    .lines_total (lines_total),
    .level       (level)
  );

  assign rd_addr       = rd_addr_q;
  assign wr_en         = wr_q.en;
  assign wr_addr       = wr_q.addr;
  assign wr_data       = wr_q.data;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_cleared_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_line_clear_ctl.sv
// Directed bench for line_clear_ctl with a behavioural board RAM, a
// write scoreboard and a reference model of the clear/compact algorithm.
module tb_line_clear_ctl;

  localparam int NR = 20;
  localparam logic [9:0] FULL = 10'h3FF;

  logic       pclk = 1'b0;
  logic       rst, new_game, lock;
  logic [4:0] rd_addr, wr_addr;
  logic [9:0] rd_data, wr_data;
  logic       wr_en, busy, done, game_over;
  logic [2:0] lines_cleared;
  logic [9:0] lines_total;
  logic [3:0] level;

  logic [9:0] mem   [NR];
  logic [9:0] board [NR];
  logic       do_load;

  typedef struct packed {
    logic [4:0] a;
    logic [9:0] d;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int exp_total = 0;
  int exp_level = 0;
  int exp_prog = 0;
  bit exp_go = 1'b0;

  line_clear_ctl dut (
    .pclk          (pclk),
    .rst           (rst),
    .new_game      (new_game),
    .lock          (lock),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .level         (level),
    .game_over     (game_over)
  );

  always #5 pclk = ~pclk;

  // Board RAM: registered read, write port, and a bulk preload from board[].
  always @(posedge pclk) begin
    if (do_load) begin
      for (int r = 0; r < NR; r++) mem[r] <= board[r];
    end else if (wr_en === 1'b1 && wr_addr < 5'(NR)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (rd_addr < 5'(NR)) ? mem[rd_addr] : 10'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge pclk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {17'b0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_board();
    @(negedge pclk) do_load = 1'b1;
    @(negedge pclk) do_load = 1'b0;
  endtask

  task automatic set_board_zero();
    for (int r = 0; r < NR; r++) board[r] = 10'h0;
  endtask

  // Reference: collect surviving rows bottom-up, stack them from the bottom,
  // queue the writes whose destination differs, then zero the freed rows.
  task automatic model_scan(output int cnt, output bit gov);
    logic [9:0] kept[$];
    int src[$];
    int d;
    cnt = 0;
    gov = 1'b0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (board[r] == FULL) cnt++;
      else begin
        kept.push_back(board[r]);
        src.push_back(r);
      end
    end
    for (int k = 0; k < kept.size(); k++) begin
      d = NR - 1 - k;
      if (d != src[k]) exp_q.push_back({5'(d), kept[k]});
      if (kept[k] != 10'h0 && d < 2) gov = 1'b1;
      board[d] = kept[k];
    end
    for (int f = cnt - 1; f >= 0; f--) begin
      exp_q.push_back({5'(f), 10'h0});
      board[f] = 10'h0;
    end
  endtask

  task automatic apply_stats(input int cnt);
    exp_total = (exp_total + cnt > 1023) ? 1023 : exp_total + cnt;
    exp_prog += cnt;
    if (exp_prog >= 10) begin
      exp_prog -= 10;
      if (exp_level < 15) exp_level++;
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge pclk);
        lat++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < NR; r++) chk({tag, "_board"}, 32'(mem[r]), 32'(board[r]));
  endtask

  task automatic finish_op(input string tag);
    @(negedge pclk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_busy_end"}, 32'(busy), 32'(0));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    check_board(tag);
  endtask

  task automatic do_lock_op(input string tag);
    int cnt;
    bit gov;
    model_scan(cnt, gov);
    @(negedge pclk) lock = 1'b1;
    @(negedge pclk) lock = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    wait_done(tag, 3 * NR + cnt + 1);
    apply_stats(cnt);
    exp_go = exp_go | gov;
    chk({tag, "_lines_cleared"}, 32'(lines_cleared), 32'(cnt));
    chk({tag, "_lines_total"}, 32'(lines_total), 32'(exp_total));
    chk({tag, "_level"}, 32'(level), 32'(exp_level));
    chk({tag, "_game_over"}, 32'(game_over), 32'(exp_go));
    finish_op(tag);
  endtask

  task automatic push_clear();
    for (int r = 0; r < NR; r++) exp_q.push_back({5'(r), 10'h0});
    set_board_zero();
    exp_total = 0;
    exp_level = 0;
    exp_prog  = 0;
    exp_go    = 1'b0;
  endtask

  task automatic check_after_clear(input string tag);
    wait_done(tag, NR + 1);
    chk({tag, "_lines_cleared"}, 32'(lines_cleared), 32'(0));
    chk({tag, "_lines_total"}, 32'(lines_total), 32'(0));
    chk({tag, "_level"}, 32'(level), 32'(0));
    chk({tag, "_game_over"}, 32'(game_over), 32'(0));
    finish_op(tag);
  endtask

  task automatic do_new_game(input string tag);
    push_clear();
    @(negedge pclk) new_game = 1'b1;
    @(negedge pclk) new_game = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    check_after_clear(tag);
  endtask

  initial begin
    int extra;
    rst = 1'b1;
    new_game = 1'b0;
    lock = 1'b0;
    do_load = 1'b0;
    set_board_zero();
    repeat (3) @(negedge pclk);
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_lines_cleared", 32'(lines_cleared), 32'(0));
    chk("rst_lines_total", 32'(lines_total), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_game_over", 32'(game_over), 32'(0));
    rst = 1'b0;

    do_new_game("ng_init");

    // Empty board: no writes, 61-cycle latency.
    set_board_zero();
    load_board();
    do_lock_op("empty");

    // One full row at the bottom.
    set_board_zero();
    board[19] = FULL;
    board[18] = 10'h003;
    load_board();
    do_lock_op("one_line");

    // Four full rows plus a partial row above.
    set_board_zero();
    for (int r = 16; r < 20; r++) board[r] = FULL;
    board[15] = 10'h201;
    load_board();
    do_lock_op("four_line");

    // Level boundary: 4 + 4 + 2 lines from a fresh game.
    do_new_game("ng_level");
    for (int n = 0; n < 2; n++) begin
      set_board_zero();
      for (int r = 16; r < 20; r++) board[r] = FULL;
      load_board();
      do_lock_op("tetris");
    end
    set_board_zero();
    board[18] = FULL;
    board[19] = FULL;
    board[17] = 10'h155;
    load_board();
    do_lock_op("level_up");
    chk("level_is_one", 32'(level), 32'(1));
    chk("total_is_ten", 32'(lines_total), 32'(10));

    // Lock during SCAN_EVAL is ignored, then new_game aborts the scan.
    for (int r = 1; r < NR; r++) board[r] = 10'(r);
    board[0] = FULL;
    load_board();
    @(negedge pclk) lock = 1'b1;
    @(negedge pclk) lock = 1'b0;
    @(negedge pclk);
    @(negedge pclk) lock = 1'b1;
    @(negedge pclk) lock = 1'b0;
    chk("abort_busy", 32'(busy), 32'(1));
    extra = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge pclk);
      if (done === 1'b1) extra++;
    end
    chk("abort_no_early_done", 32'(extra), 32'(0));
    push_clear();
    new_game = 1'b1;
    @(negedge pclk) new_game = 1'b0;
    check_after_clear("abort");
    extra = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge pclk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("abort_lock_not_queued", 32'(extra), 32'(0));

    // Non-empty row ends up in the spawn area: sticky game over.
    set_board_zero();
    for (int r = 1; r < NR; r++) board[r] = 10'h001;
    load_board();
    do_lock_op("game_over");
    repeat (5) @(negedge pclk);
    chk("game_over_held", 32'(game_over), 32'(1));
    set_board_zero();
    load_board();
    do_lock_op("game_over_sticky");
    do_new_game("ng_clear_go");

    // Synchronous reset mid-scan drops the pending compaction write.
    set_board_zero();
    board[19] = FULL;
    board[18] = 10'h003;
    load_board();
    @(negedge pclk) lock = 1'b1;
    @(negedge pclk) lock = 1'b0;
    repeat (5) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_mid_wr_en", 32'(wr_en), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_mid_idle", 32'(busy), 32'(0));
    chk("rst_mid_row19", 32'(mem[19]), 32'(FULL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
